regfile: RTL and testbench
==========================

Name: regfile

Overview:
- Architectural register file with rename tags. It sits directly downstream of the reorder buffer's commit port and upstream of its operand-search port.
- Holds 32 × 32-bit values plus, per register, the ROB id of the youngest in-flight producer.
- The decoder reports each issued instruction's rd and ROB id.
- Two source lookups return either a ready value or a dependency tag. The ROB then resolves the tag against its own in-flight results.

Parameters:
- ROB_WIDTH, 3, width of ROB ids; must match the shared ROB_WIDTH define.
- REG_NUM, 32, number of architectural registers (x0..x31).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  pause; state updates only when high
- clear  input  1  mispredict flush from ROB (one-cycle pulse)
- issue_valid  input  1  decoder issues an instruction this cycle
- issue_rd  input  5  destination register of issued instruction (0 = none)
- issue_rob_id  input  ROB_WIDTH  ROB slot allocated to issued instruction
- rs1_id  input  5  source register 1 of the instruction being issued
- rs2_id  input  5  source register 2 of the instruction being issued
- commit_ready  input  1  ROB commits a register write
- commit_rob_id  input  ROB_WIDTH  ROB slot being committed
- commit_reg_id  input  5  destination register being committed
- commit_val  input  32  committed value
- search_has_dep_1  output  1  rs1 awaits an in-flight producer
- search_rob_id_1  output  ROB_WIDTH  producer tag for rs1 (0 when no dep)
- search_val_1  output  32  rs1 value (0 when dep)
- search_has_dep_2, search_rob_id_2, search_val_2: same set of outputs for rs2.

Behaviour:
- Reset: is asynchronous on rst_in, independent of rdy_in. All values, dep_valid bits and tags go to 0, so every search output reads 0 / no dep.
- Search outputs are combinational from current state plus same-cycle commit bypass. Zero added latency; the ROB registers the answer.
- Lookup for port k with register r:
  - If r == 0: no dep, value 0.
  - Else if dep_valid[r] and commit_ready and commit_reg_id == r and commit_rob_id == tag[r]: no dep, value = commit_val (bypass).
  - Else if dep_valid[r]: has_dep = 1, rob_id = tag[r], val = 0.
  - Else: no dep, val = value[r].
- Lookups ignore the same-cycle issue. An instruction with rd == rs sees the older producer (e.g. addi x1,x1,1).
- Sequential, only when rdy_in == 1:
  - Commit: if commit_ready and commit_reg_id != 0, value[commit_reg_id] <= commit_val always. dep_valid is cleared only if tag == commit_rob_id; otherwise a younger producer owns the register and the tag is kept.
  - Issue: if issue_valid, !clear and issue_rd != 0, set dep_valid[issue_rd] <= 1 and tag <= issue_rob_id.
  - Issue and commit to the same register in one cycle: issue wins for dep_valid and tag; the value is still written.
  - Clear: all dep_valid <= 0 and tags <= 0. A same-cycle commit still writes its value. A same-cycle issue is dropped.
- rdy_in low: all state held; outputs keep reflecting current state.
- x0 is never written and never tagged.
- Tag reuse after ROB wrap-around is safe, because a tag matches only while its slot is in flight.
- No state machine beyond the per-register valid/tag flags. Implementation is about 150–200 lines.

Decomposition:
- Shared header (existing defines file): ROB_WIDTH, ROB_SIZE, REG_NUM.
- One natural sub-module: regfile_lookup, the combinational per-port lookup with commit bypass, instantiated twice.

Test Plan:
- Reset, then query rs1 = 5, rs2 = 0: no dep, val 0 on both ports.
- Issue rd = 3, rob 2. Next cycle query rs1 = 3: has_dep = 1, rob_id = 2. Commit reg 3, rob 2, val 0xDEADBEEF. That same cycle query returns no dep, val 0xDEADBEEF via bypass; the following cycle returns the same from storage.
- Issue rd = 4, rob 1, then rd = 4, rob 5. Commit reg 4, rob 1, val 7: value[4] = 7, but query still returns dep, rob 5. Commit rob 5, val 9: no dep, val 9.
- Same cycle: issue rd = 6, rob 3, and commit reg 6 from an older tag with val 11. Next query: dep, rob 3; after the rob 3 commit, val reflects rob 3's value.
- Tag x1 with rob 4 and x2 with rob 5, then pulse clear with a simultaneous issue rd = 7, rob 6. Next cycle no register has a dep: x1 and x2 return their previous committed values, and x7 is untagged.
- Issue rd = 0, rob 2 and commit reg 0, val 5: x0 stays 0 with no dep. With rdy_in low, issue rd = 8 causes no change.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing constants for the architectural register file.
//   ROB_WIDTH : width of a reorder-buffer slot id
//   ROB_SIZE  : number of ROB slots
//   REG_NUM   : number of architectural registers (x0..x31)
//   REG_ID_W  : width of an architectural register index
package regfile_pkg;
    localparam int ROB_WIDTH = 3;
    localparam int ROB_SIZE  = 1 << ROB_WIDTH;
    localparam int REG_NUM   = 32;
    localparam int REG_ID_W  = 5;
endpackage

// File: rtl/regfile_lookup.sv
// One source-operand lookup port with same-cycle commit bypass.
// Ports:
//   reg_id             register being looked up
//   reg_dep/reg_tag    stored in-flight flag and producer tag of that register
//   reg_val            stored architectural value of that register
//   commit_*           ROB commit port, used for the bypass
//   has_dep/rob_id/val lookup result (rob_id 0 when no dep, val 0 when dep)
import regfile_pkg::*;

module regfile_lookup #(
    parameter int ROB_WIDTH = regfile_pkg::ROB_WIDTH
) (
    input  logic [REG_ID_W-1:0]  reg_id,
    input  logic                 reg_dep,
    input  logic [ROB_WIDTH-1:0] reg_tag,
    input  logic [31:0]          reg_val,
    input  logic                 commit_ready,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [REG_ID_W-1:0]  commit_reg_id,
    input  logic [31:0]          commit_val,
    output logic                 has_dep,
    output logic [ROB_WIDTH-1:0] rob_id,
    output logic [31:0]          val
);
    always_comb begin
        has_dep = 1'b0;
        rob_id  = '0;
        val     = '0;
        if (reg_id == '0) begin
            // x0 reads as constant zero
        end else if (reg_dep && commit_ready && commit_reg_id == reg_id
                     && commit_rob_id == reg_tag) begin
            // the producer we wait on is committing right now
            val = commit_val;
        end else if (reg_dep) begin
            has_dep = 1'b1;
            rob_id  = reg_tag;
        end else begin
            val = reg_val;
        end
    end
endmodule

// File: rtl/regfile.sv
// Architectural register file with rename tags.
// Holds REG_NUM x 32-bit values and, per register, the ROB id of the youngest
// in-flight producer. Two combinational source lookups return either a ready
// value or a dependency tag.
// Ports:
//   clk_in, rst_in (async, active high), rdy_in (state advances only when high)
//   clear                  mispredict flush: drops all tags, same-cycle issue
//   issue_*                decoder rename of rd to a ROB slot
//   rs1_id, rs2_id         source registers to look up
//   commit_*               ROB commit of a register write
//   search_*_1, search_*_2 lookup results for rs1 and rs2
import regfile_pkg::*;

module regfile #(
    parameter int ROB_WIDTH = regfile_pkg::ROB_WIDTH,
    parameter int REG_NUM   = regfile_pkg::REG_NUM
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 issue_valid,
    input  logic [REG_ID_W-1:0]  issue_rd,
    input  logic [ROB_WIDTH-1:0] issue_rob_id,
    input  logic [REG_ID_W-1:0]  rs1_id,
    input  logic [REG_ID_W-1:0]  rs2_id,
    input  logic                 commit_ready,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [REG_ID_W-1:0]  commit_reg_id,
    input  logic [31:0]          commit_val,
    output logic                 search_has_dep_1,
    output logic [ROB_WIDTH-1:0] search_rob_id_1,
    output logic [31:0]          search_val_1,
    output logic                 search_has_dep_2,
    output logic [ROB_WIDTH-1:0] search_rob_id_2,
    output logic [31:0]          search_val_2
);
    logic [31:0]          value_q   [REG_NUM];
    logic [ROB_WIDTH-1:0] tag_q     [REG_NUM];
    logic [REG_NUM-1:0]   dep_valid_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            dep_valid_q <= '0;
        end else if (rdy_in) begin
            if (commit_ready && commit_reg_id != '0) begin
                value_q[commit_reg_id] <= commit_val;
                // a younger producer keeps ownership unless this is its tag
                if (tag_q[commit_reg_id] == commit_rob_id)
                    dep_valid_q[commit_reg_id] <= 1'b0;
            end
            // later assignments override the commit so issue wins on a clash
            if (clear) begin
                dep_valid_q <= '0;
                for (int i = 0; i < REG_NUM; i++)
                    tag_q[i] <= '0;
            end else if (issue_valid && issue_rd != '0) begin
                dep_valid_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]       <= issue_rob_id;
            end
        end
    end

    regfile_lookup #(.ROB_WIDTH(ROB_WIDTH)) u_lookup_1 (
        .reg_id        (rs1_id),
        .reg_dep       (dep_valid_q[rs1_id]),
        .reg_tag       (tag_q[rs1_id]),
        .reg_val       (value_q[rs1_id]),
        .commit_ready  (commit_ready),
        .commit_rob_id (commit_rob_id),
        .commit_reg_id (commit_reg_id),
        .commit_val    (commit_val),
        .has_dep       (search_has_dep_1),
        .rob_id        (search_rob_id_1),
        .val           (search_val_1)
    );

    regfile_lookup #(.ROB_WIDTH(ROB_WIDTH)) u_lookup_2 (
        .reg_id        (rs2_id),
        .reg_dep       (dep_valid_q[rs2_id]),
        .reg_tag       (tag_q[rs2_id]),
        .reg_val       (value_q[rs2_id]),
        .commit_ready  (commit_ready),
        .commit_rob_id (commit_rob_id),
        .commit_reg_id (commit_reg_id),
        .commit_val    (commit_val),
        .has_dep       (search_has_dep_2),
        .rob_id        (search_rob_id_2),
        .val           (search_val_2)
    );
endmodule

// File: tb/tb_regfile.sv
module tb_regfile;
    localparam int RW = 3;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [RW-1:0] issue_rob_id;
    logic [4:0]    rs1_id;
    logic [4:0]    rs2_id;
    logic          commit_ready;
    logic [RW-1:0] commit_rob_id;
    logic [4:0]    commit_reg_id;
    logic [31:0]   commit_val;
    logic          search_has_dep_1;
    logic [RW-1:0] search_rob_id_1;
    logic [31:0]   search_val_1;
    logic          search_has_dep_2;
    logic [RW-1:0] search_rob_id_2;
    logic [31:0]   search_val_2;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: architectural state as plain arrays
    logic [31:0]   m_val [32];
    bit            m_dep [32];
    logic [RW-1:0] m_tag [32];

    regfile dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .clear            (clear),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_rob_id     (issue_rob_id),
        .rs1_id           (rs1_id),
        .rs2_id           (rs2_id),
        .commit_ready     (commit_ready),
        .commit_rob_id    (commit_rob_id),
        .commit_reg_id    (commit_reg_id),
        .commit_val       (commit_val),
        .search_has_dep_1 (search_has_dep_1),
        .search_rob_id_1  (search_rob_id_1),
        .search_val_1     (search_val_1),
        .search_has_dep_2 (search_has_dep_2),
        .search_rob_id_2  (search_rob_id_2),
        .search_val_2     (search_val_2)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_dep[i] = 1'b0;
            m_tag[i] = '0;
        end
    endtask

    function automatic void model_lookup(input logic [4:0] r, output logic dep,
                                         output logic [RW-1:0] tag, output logic [31:0] v);
        dep = 1'b0; tag = '0; v = '0;
        if (r == 0) return;
        if (m_dep[r] && commit_ready && commit_reg_id == r && commit_rob_id == m_tag[r])
            v = commit_val;
        else if (m_dep[r]) begin
            dep = 1'b1;
            tag = m_tag[r];
        end else
            v = m_val[r];
    endfunction

    task automatic model_update();
        if (!rdy_in) return;
        if (commit_ready && commit_reg_id != 0) begin
            m_val[commit_reg_id] = commit_val;
            if (m_tag[commit_reg_id] == commit_rob_id) m_dep[commit_reg_id] = 1'b0;
        end
        if (clear) begin
            for (int i = 0; i < 32; i++) begin
                m_dep[i] = 1'b0;
                m_tag[i] = '0;
            end
        end else if (issue_valid && issue_rd != 0) begin
            m_dep[issue_rd] = 1'b1;
            m_tag[issue_rd] = issue_rob_id;
        end
    endtask

    // inputs are driven 1ns after posedge; outputs compared at the negedge
    task automatic settle();
        logic d; logic [RW-1:0] t; logic [31:0] v;
        #4;
        model_lookup(rs1_id, d, t, v);
        check("dep1", {31'b0, search_has_dep_1}, {31'b0, d});
        check("tag1", {{(32-RW){1'b0}}, search_rob_id_1}, {{(32-RW){1'b0}}, t});
        check("val1", search_val_1, v);
        model_lookup(rs2_id, d, t, v);
        check("dep2", {31'b0, search_has_dep_2}, {31'b0, d});
        check("tag2", {{(32-RW){1'b0}}, search_rob_id_2}, {{(32-RW){1'b0}}, t});
        check("val2", search_val_2, v);
    endtask

    task automatic clock();
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic idle();
        clear = 0; issue_valid = 0; issue_rd = 0; issue_rob_id = 0;
        commit_ready = 0; commit_rob_id = 0; commit_reg_id = 0; commit_val = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RW-1:0] rob);
        issue_valid = 1; issue_rd = rd; issue_rob_id = rob;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [RW-1:0] rob, input logic [31:0] v);
        commit_ready = 1; commit_reg_id = rd; commit_rob_id = rob; commit_val = v;
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; rs1_id = 5; rs2_id = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        settle();
        check("rst_val1", search_val_1, 32'h0);
        check("rst_dep1", {31'b0, search_has_dep_1}, 32'h0);
        check("rst_dep2", {31'b0, search_has_dep_2}, 32'h0);
        @(posedge clk_in); #1;
        rst_in = 0;

        // rename then commit with bypass
        issue(3, 2); settle(); clock();
        idle(); rs1_id = 3; settle();
        check("x3_dep", {31'b0, search_has_dep_1}, 32'd1);
        check("x3_tag", {29'b0, search_rob_id_1}, 32'd2);
        clock();
        commit(3, 2, 32'hDEADBEEF); settle();
        check("x3_bypass_dep", {31'b0, search_has_dep_1}, 32'd0);
        check("x3_bypass_val", search_val_1, 32'hDEADBEEF);
        clock();
        idle(); settle();
        check("x3_stored", search_val_1, 32'hDEADBEEF);
        clock();

        // younger producer keeps ownership
        issue(4, 1); settle(); clock();
        issue(4, 5); settle(); clock();
        idle(); commit(4, 1, 7); rs1_id = 4; settle();
        check("x4_old_commit_dep", {31'b0, search_has_dep_1}, 32'd1);
        check("x4_old_commit_tag", {29'b0, search_rob_id_1}, 32'd5);
        clock();
        idle(); settle();
        check("x4_still_dep", {29'b0, search_rob_id_1}, 32'd5);
        clock();
        commit(4, 5, 9); settle(); clock();
        idle(); settle();
        check("x4_final", search_val_1, 32'd9);
        clock();

        // issue and commit to the same register in one cycle
        issue(6, 3); commit(6, 1, 11); rs1_id = 6; settle(); clock();
        idle(); settle();
        check("x6_issue_wins", {29'b0, search_rob_id_1}, 32'd3);
        clock();
        commit(6, 3, 22); settle(); clock();
        idle(); settle();
        check("x6_final", search_val_1, 32'd22);
        clock();

        // flush drops tags and same-cycle issue
        commit(1, 0, 32'h111); settle(); clock();
        idle(); commit(2, 0, 32'h222); settle(); clock();
        idle(); issue(1, 4); settle(); clock();
        idle(); issue(2, 5); settle(); clock();
        idle(); clear = 1; issue(7, 6); settle(); clock();
        idle(); rs1_id = 1; rs2_id = 2; settle();
        check("x1_after_clear", search_val_1, 32'h111);
        check("x2_after_clear", search_val_2, 32'h222);
        clock();
        rs1_id = 7; settle();
        check("x7_untagged", {31'b0, search_has_dep_1}, 32'd0);
        clock();

        // x0 and pause
        issue(0, 2); commit(0, 0, 5); rs1_id = 0; settle(); clock();
        idle(); settle();
        check("x0_zero", search_val_1, 32'd0);
        clock();
        rdy_in = 0; issue(8, 1); rs1_id = 8; settle(); clock();
        idle(); settle();
        check("x8_paused", {31'b0, search_has_dep_1}, 32'd0);
        clock();
        rdy_in = 1;

        // randomized traffic, mostly on low registers to force collisions
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] r;
            idle();
            rdy_in = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 39) == 0);
            rs1_id = 5'($urandom_range(0, 9));
            rs2_id = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                issue(5'($urandom_range(0, 9)), RW'($urandom_range(0, 7)));
            if ($urandom_range(0, 2) != 0) begin
                r = 5'($urandom_range(0, 9));
                commit(r, ($urandom_range(0, 2) != 0) ? m_tag[r] : RW'($urandom_range(0, 7)),
                       $urandom);
            end
            if (c == 1500) begin
                // asynchronous reset between edges, with rdy_in low
                idle(); rdy_in = 0; rs1_id = 3;
                rst_in = 1;
                model_reset();
                #2;
                check("async_rst_val", search_val_1, 32'd0);
                check("async_rst_dep", {31'b0, search_has_dep_1}, 32'd0);
                @(posedge clk_in); #1;
                rst_in = 0; rdy_in = 1;
            end
            settle();
            clock();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
